// File: rtl/rv32i_core.sv
// Single-cycle RV32I integer core with an 8-bit byte-addressed PC.
// Instruction and data memories are external; all outputs except pc are combinational.

module rv32i_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            registers[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : registers[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : registers[raddr_b];
endmodule

module rv32i_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] mem_data,
    output logic [7:0]  pc,
    output logic [31:0] mem_addr,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm_i, imm_s, imm_u;
    logic [7:0]  imm_b8, imm_j8;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] pc_ext, pc_link;
    logic [31:0] addr_i, addr_s, alu_res;
    logic [7:0]  next_pc;
    logic        rd_we, store_en;
    logic [31:0] rd_data;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign alt    = instruction[30];

    assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_u  = {instruction[31:12], 12'd0};
    // Branch/jump targets wrap modulo 256, so only the low offset byte matters.
    assign imm_b8 = {instruction[27:25], instruction[11:8], 1'b0};
    assign imm_j8 = {instruction[27:21], 1'b0};

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic sub,
                                        input logic arith);
        logic signed [31:0] sa, sb, sra_r;
        sa    = a;
        sb    = b;
        sra_r = sa >>> b[4:0];
        case (f3)
            3'd0:    alu = sub ? (a - b) : (a + b);
            3'd1:    alu = a << b[4:0];
            3'd2:    alu = (sa < sb) ? 32'd1 : 32'd0;
            3'd3:    alu = (a < b) ? 32'd1 : 32'd0;
            3'd4:    alu = a ^ b;
            3'd5:    alu = arith ? sra_r : (a >> b[4:0]);
            3'd6:    alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0:    branch_taken = (a == b);
            3'd1:    branch_taken = (a != b);
            3'd4:    branch_taken = (sa < sb);
            3'd5:    branch_taken = (sa >= sb);
            3'd6:    branch_taken = (a < b);
            3'd7:    branch_taken = (a >= b);
            default: branch_taken = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            3'd0:    load_ext = {{24{s[7]}}, s[7:0]};
            3'd1:    load_ext = {{16{s[15]}}, s[15:0]};
            3'd4:    load_ext = {24'd0, s[7:0]};
            3'd5:    load_ext = {16'd0, s[15:0]};
            default: load_ext = word;
        endcase
    endfunction

    // Sub-word stores merge into the word currently read back from memory.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] src,
                                                input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] mask;
        case (f3)
            3'd0:    mask = 32'h0000_00FF;
            3'd1:    mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        if (f3 == 3'd2) begin
            store_merge = src;
        end else begin
            store_merge = (word & ~(mask << {off, 3'b000})) | ((src & mask) << {off, 3'b000});
        end
    endfunction

    rv32i_regfile register_file_inst (
        .clk     (clk),
        .rst     (rst),
        .we      (rd_we),
        .waddr   (rd),
        .wdata   (rd_data),
        .raddr_a (rs1),
        .raddr_b (rs2),
        .rdata_a (rs1_val),
        .rdata_b (rs2_val)
    );

    assign pc_ext  = {24'd0, pc};
    assign pc_link = pc_ext + 32'd4;
    assign addr_i  = rs1_val + imm_i;
    assign addr_s  = rs1_val + imm_s;
    assign alu_res = alu(rs1_val, (opcode == OP_REG) ? rs2_val : imm_i, funct3,
                         (opcode == OP_REG) && alt, alt);

    always_comb begin
        next_pc        = pc + 8'd4;
        rd_we          = 1'b0;
        rd_data        = '0;
        store_en       = 1'b0;
        mem_addr       = alu_res;
        mem_write_data = rs2_val;
        case (opcode)
            OP_LUI: begin
                rd_we   = 1'b1;
                rd_data = imm_u;
            end
            OP_AUIPC: begin
                rd_we   = 1'b1;
                rd_data = pc_ext + imm_u;
            end
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_data = pc_link;
                next_pc = pc + imm_j8;
            end
            OP_JALR: begin
                if (funct3 == 3'd0) begin
                    rd_we   = 1'b1;
                    rd_data = pc_link;
                    next_pc = {addr_i[7:1], 1'b0};
                end
            end
            OP_BRANCH: begin
                if (branch_taken(rs1_val, rs2_val, funct3)) begin
                    next_pc = pc + imm_b8;
                end
            end
            OP_LOAD: begin
                mem_addr = addr_i;
                if (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                    rd_we   = 1'b1;
                    rd_data = load_ext(mem_data, addr_i[1:0], funct3);
                end
            end
            OP_STORE: begin
                mem_addr = addr_s;
                if (funct3 inside {3'd0, 3'd1, 3'd2}) begin
                    store_en       = 1'b1;
                    mem_write_data = store_merge(mem_data, rs2_val, addr_s[1:0], funct3);
                end
            end
            OP_IMM, OP_REG: begin
                rd_we   = 1'b1;
                rd_data = alu_res;
            end
            default: begin
            end
        endcase
    end

    assign mem_write_enable = store_en & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else begin
            pc <= next_pc;
        end
    end
endmodule

// File: tb/tb_rv32i_core.sv
// Directed-program bench for rv32i_core: a queue of expected per-cycle retirements
// is checked by an independent monitor against pc, store outputs and register state.

module tb_rv32i_core;
    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] mem_data;
    logic [7:0]  pc;
    logic [31:0] mem_addr;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];
    logic        clear_dmem;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [7:0]  pc;
        logic        st;
        logic [31:0] addr;
        logic [31:0] data;
        int          ridx;
        logic [31:0] rval;
    } exp_t;

    exp_t sb[$];

    rv32i_core dut (
        .clk              (clk),
        .rst              (rst),
        .instruction      (instruction),
        .mem_data         (mem_data),
        .pc               (pc),
        .mem_addr         (mem_addr),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instruction = imem[pc[7:2]];
    assign mem_data    = dmem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (clear_dmem) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
        end else if (mem_write_enable) begin
            dmem[mem_addr[7:2]] <= mem_write_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3,
                                          input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rd,
                                          input logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic push(input logic [7:0] epc, input logic st, input logic [31:0] addr,
                        input logic [31:0] data, input int ridx, input logic [31:0] rval);
        exp_t e;
        e.pc = epc; e.st = st; e.addr = addr; e.data = data; e.ridx = ridx; e.rval = rval;
        sb.push_back(e);
    endtask

    // Monitor: one retirement per cycle while out of reset.
    always @(negedge clk) begin
        if (rst && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("pc@%02h", e.pc), {24'd0, pc}, {24'd0, e.pc});
            check($sformatf("we@%02h", e.pc), {31'd0, mem_write_enable}, {31'd0, e.st});
            if (e.st) begin
                check($sformatf("addr@%02h", e.pc), mem_addr, e.addr);
                check($sformatf("wdata@%02h", e.pc), mem_write_data, e.data);
            end
            if (e.ridx >= 0) begin
                check($sformatf("x%0d@%02h", e.ridx, e.pc),
                      dut.register_file_inst.registers[e.ridx], e.rval);
            end
        end
    end

    localparam logic [6:0] LOAD = 7'b0000011;
    localparam logic [6:0] IMM  = 7'b0010011;

    initial begin
        bit found;
        n_checks   = 0;
        n_pass     = 0;
        clear_dmem = 1'b1;
        rst        = 1'b1;
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
        imem[0]  = enc_i(5, 0, 0, 1, IMM);            // 00 ADDI x1,x0,5
        imem[1]  = enc_i(-3, 0, 0, 2, IMM);           // 04 ADDI x2,x0,-3
        imem[2]  = enc_r(0, 2, 1, 0, 3);              // 08 ADD x3,x1,x2
        imem[3]  = enc_r(32'h20, 1, 2, 5, 4);         // 0C SRA x4,x2,x1
        imem[4]  = enc_b(12, 1, 1, 0);                // 10 BEQ x1,x1,+12
        imem[5]  = enc_i(9, 0, 0, 14, IMM);           // 14 skipped
        imem[6]  = enc_i(0, 1, 0, 0, 7'b1100111);     // 18 JALR x0,0(x1)
        imem[7]  = enc_r(0, 2, 1, 3, 5);              // 1C SLTU x5,x1,x2
        imem[8]  = enc_j(-8, 1);                      // 20 JAL x1,-8
        imem[9]  = enc_b(8, 1, 1, 1);                 // 24 BNE x1,x1,+8
        imem[10] = enc_i(5, 0, 0, 1, IMM);            // 28 ADDI x1,x0,5
        imem[11] = enc_s(8, 1, 0, 2);                 // 2C SW x1,8(x0)
        imem[12] = enc_i(8, 0, 2, 6, LOAD);           // 30 LW x6,8(x0)
        imem[13] = enc_s(9, 2, 0, 0);                 // 34 SB x2,9(x0)
        imem[14] = enc_i(8, 0, 2, 7, LOAD);           // 38 LW x7,8(x0)
        imem[15] = enc_i(9, 0, 0, 8, LOAD);           // 3C LB x8,9(x0)
        imem[16] = enc_i(9, 0, 4, 9, LOAD);           // 40 LBU x9,9(x0)
        imem[17] = enc_i(7, 0, 0, 0, IMM);            // 44 ADDI x0,x0,7
        imem[18] = enc_s(10, 2, 0, 1);                // 48 SH x2,10(x0)
        imem[19] = enc_i(11, 0, 1, 10, LOAD);         // 4C LH x10,11(x0)
        imem[20] = enc_u(32'h12345, 11, 7'b0110111);  // 50 LUI x11,0x12345
        imem[21] = enc_u(1, 12, 7'b0010111);          // 54 AUIPC x12,1
        imem[22] = 32'h0000_0073;                     // 58 ECALL
        imem[23] = enc_j(160, 0);                     // 5C JAL x0,+160
        imem[63] = enc_i(1, 0, 0, 13, IMM);           // FC ADDI x13,x0,1

        push(8'h00, 0, 0, 0, -1, 0);
        push(8'h04, 0, 0, 0, 1, 32'd5);
        push(8'h08, 0, 0, 0, 2, 32'hFFFF_FFFD);
        push(8'h0C, 0, 0, 0, 3, 32'd2);
        push(8'h10, 0, 0, 0, 4, 32'hFFFF_FFFF);
        push(8'h1C, 0, 0, 0, -1, 0);
        push(8'h20, 0, 0, 0, 5, 32'd1);
        push(8'h18, 0, 0, 0, 1, 32'h24);
        push(8'h24, 0, 0, 0, -1, 0);
        push(8'h28, 0, 0, 0, -1, 0);
        push(8'h2C, 1, 32'd8, 32'd5, 1, 32'd5);
        push(8'h30, 0, 0, 0, -1, 0);
        push(8'h34, 1, 32'd9, 32'h0000_FD05, 6, 32'd5);
        push(8'h38, 0, 0, 0, -1, 0);
        push(8'h3C, 0, 0, 0, 7, 32'h0000_FD05);
        push(8'h40, 0, 0, 0, 8, 32'hFFFF_FFFD);
        push(8'h44, 0, 0, 0, 9, 32'h0000_00FD);
        push(8'h48, 1, 32'd10, 32'hFFFD_FD05, 0, 32'd0);
        push(8'h4C, 0, 0, 0, -1, 0);
        push(8'h50, 0, 0, 0, 10, 32'h0000_00FF);
        push(8'h54, 0, 0, 0, 11, 32'h1234_5000);
        push(8'h58, 0, 0, 0, 12, 32'h0000_1054);
        push(8'h5C, 0, 0, 0, 13, 32'd0);
        push(8'hFC, 0, 0, 0, -1, 0);
        push(8'h00, 0, 0, 0, 13, 32'd1);
        push(8'h04, 0, 0, 0, 14, 32'd0);

        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_pc", {24'd0, pc}, 32'd0);
        check("reset_we", {31'd0, mem_write_enable}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("reset_x%0d", i), dut.register_file_inst.registers[i], 32'd0);
        end
        clear_dmem = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;

        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check("trace_drained", sb.size(), 32'd0);

        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (pc == 8'h2C) found = 1'b1;
        end
        check("reach_store_2c", {31'd0, found}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_pc", {24'd0, pc}, 32'd0);
        check("async_rst_we", {31'd0, mem_write_enable}, 32'd0);
        check("async_rst_x1", dut.register_file_inst.registers[1], 32'd0);
        @(posedge clk);
        #1;
        check("no_store_in_rst", dmem[2], 32'hFFFD_FD05);
        check("pc_held_in_rst", {24'd0, pc}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
